alu_cmd_sequencer: RTL

//   Command sequencer between the UART byte interface and the 16-bit ALU. Assembles a 5-byte

---
 rtl/alu_ctrl_pkg.sv | 37 +++
 rtl/inter_byte_timer.sv | 39 +++
 rtl/alu_cmd_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer.
// Contents: FSM state encoding, frame header tag, frame/response byte
// counts, STAT byte field positions, and a helper that packs the STAT byte.
package alu_ctrl_pkg;

    // FSM state encoding (plain constants so legacy code can compare directly)
    localparam int unsigned STATE_W = 4;
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_GET_AH  = 4'd1;
    localparam logic [3:0] ST_GET_AL  = 4'd2;
    localparam logic [3:0] ST_GET_BH  = 4'd3;
    localparam logic [3:0] ST_GET_BL  = 4'd4;
    localparam logic [3:0] ST_EXEC    = 4'd5;
    localparam logic [3:0] ST_SEND_ST = 4'd6;
    localparam logic [3:0] ST_SEND_RH = 4'd7;
    localparam logic [3:0] ST_SEND_RL = 4'd8;

    // Header byte: tag in [7:3], opcode in [2:0]
    localparam logic [4:0] HDR_TAG_DEFAULT = 5'b10100;
    localparam int unsigned SEL_W = 3;

    localparam int unsigned FRAME_BYTES = 5;
    localparam int unsigned RESP_BYTES  = 3;

    // STAT byte layout: {zero, 4'b0000, sel}
    localparam int unsigned STAT_ZERO_BIT = 7;
    localparam int unsigned STAT_SEL_LSB  = 0;

    function automatic logic [7:0] make_stat(input logic zero, input logic [SEL_W-1:0] sel);
        logic [7:0] stat;
        stat = 8'h00;
        stat[STAT_ZERO_BIT] = zero;
        stat[STAT_SEL_LSB +: SEL_W] = sel;
        return stat;
    endfunction

endpackage

// File: rtl/inter_byte_timer.sv
// Inter-byte timeout timer for the command sequencer.
// Counts enabled cycles since the last clear; expire is a combinational
// one-cycle pulse on the cycle the count would reach TIMEOUT_CYC.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   clr     in   restart the count (a byte arrived); overrides expiry
//   en      in   count while high; the count is held at zero while low
//   expire  out  timeout reached this cycle
module inter_byte_timer #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    // Count value TERM means TIMEOUT_CYC-1 idle cycles have already elapsed,
    // so this cycle is the TIMEOUT_CYC-th one. A same-cycle clear wins.
    assign expire = en && !clr && (count == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || !en || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer between the UART byte interface and the 16-bit ALU.
// Receives HDR, A[15:8], A[7:0], B[15:8], B[7:0]; drives registered
// operands/opcode to the external ALU; captures RESULT/ZERO for one cycle
// in EXEC; returns STAT{zero,0000,sel}, R[15:8], R[7:0] via valid/ready.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   rx_valid, rx_data   one-cycle received-byte strobe and byte
//   tx_data, tx_valid   response byte, held until tx_ready at a posedge
//   tx_ready            UART TX accept
//   alu_a, alu_b        registered ALU operands
//   alu_sel             registered ALU opcode
//   alu_result, alu_zero  combinational ALU outputs
//   busy                high in every state except IDLE
//   err                 one-cycle pulse: bad header, inter-byte timeout, RX overrun
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a header byte with a matching tag
// GET_AH     | waiting for operand A high byte (timeout armed)
// GET_AL     | waiting for operand A low byte (timeout armed)
// GET_BH     | waiting for operand B high byte (timeout armed)
// GET_BL     | waiting for operand B low byte (timeout armed)
// EXEC       | single cycle; ALU output captured
// SEND_ST    | presenting STAT byte
// SEND_RH    | presenting result high byte
// SEND_RL    | presenting result low byte
module alu_cmd_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [4:0]  HDR_TAG     = HDR_TAG_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        busy,
    output logic        err
);

    logic [STATE_W-1:0] state;
    logic [15:0]        res_q;
    logic               zero_q;
    logic               in_get;
    logic               in_send;
    logic               timer_expire;

    assign in_get  = (state == ST_GET_AH) || (state == ST_GET_AL) ||
                     (state == ST_GET_BH) || (state == ST_GET_BL);
    assign in_send = (state == ST_SEND_ST) || (state == ST_SEND_RH) ||
                     (state == ST_SEND_RL);

    inter_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_valid),
        .en     (in_get),
        .expire (timer_expire)
    );

    // TX side is a pure decode of the state and capture registers, so an
    // async reset drops tx_valid immediately and tx_data cannot change
    // while a byte is waiting for tx_ready.
    assign busy     = (state != ST_IDLE);
    assign tx_valid = in_send;

    always_comb begin
        tx_data = 8'h00;
        case (state)
            ST_SEND_ST: tx_data = make_stat(zero_q, alu_sel);
            ST_SEND_RH: tx_data = res_q[15:8];
            ST_SEND_RL: tx_data = res_q[7:0];
            default:    tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            alu_a   <= 16'h0000;
            alu_b   <= 16'h0000;
            alu_sel <= 3'd0;
            res_q   <= 16'h0000;
            zero_q  <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data[7:3] == HDR_TAG) begin
                            alu_sel <= rx_data[2:0];
                            state   <= ST_GET_AH;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_GET_AH: begin
                    if (rx_valid) begin
                        alu_a[15:8] <= rx_data;
                        state       <= ST_GET_AL;
                    end
                end
                ST_GET_AL: begin
                    if (rx_valid) begin
                        alu_a[7:0] <= rx_data;
                        state      <= ST_GET_BH;
                    end
                end
                ST_GET_BH: begin
                    if (rx_valid) begin
                        alu_b[15:8] <= rx_data;
                        state       <= ST_GET_BL;
                    end
                end
                ST_GET_BL: begin
                    if (rx_valid) begin
                        alu_b[7:0] <= rx_data;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Operands settled during the GET_BL->EXEC edge; the ALU
                    // output is valid for the whole EXEC cycle.
                    res_q  <= alu_result;
                    zero_q <= alu_zero;
                    state  <= ST_SEND_ST;
                    if (rx_valid) begin
                        err <= 1'b1;
                    end
                end
                ST_SEND_ST: begin
                    if (tx_ready) begin
                        state <= ST_SEND_RH;
                    end
                    if (rx_valid) begin
                        err <= 1'b1;
                    end
                end
                ST_SEND_RH: begin
                    if (tx_ready) begin
                        state <= ST_SEND_RL;
                    end
                    if (rx_valid) begin
                        err <= 1'b1;
                    end
                end
                ST_SEND_RL: begin
                    if (tx_ready) begin
                        state <= ST_IDLE;
                    end
                    if (rx_valid) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Expiry is already suppressed when a byte arrives in the same
            // cycle, so this never collides with an operand load above.
            if (timer_expire) begin
                err   <= 1'b1;
                state <= ST_IDLE;
            end
        end
    end

endmodule
